// File: rtl/stream_downsizer.sv
// stream_downsizer
// Wide-to-narrow stream serializer feeding the source side of the gray-coded
// CDC FIFO. Each accepted IN_WIDTH word is emitted as RATIO beats of
// OW = IN_WIDTH/RATIO bits. Beats are never dropped or reordered.
//
// Optional feature macro: STREAM_DOWNSIZER_LAST_EN
//   defined   -> out_last_o port present, high on the final beat of a word
//   undefined -> no out_last_o port, framing is implicit by beat count
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   in_data_i    wide input word
//   in_valid_i   input word valid
//   in_ready_o   word accepted this cycle (combinational, 0 during reset)
//   out_data_o   current narrow beat
//   out_valid_o  beat valid (from flops only)
//   out_ready_i  downstream accepts the beat
//   out_last_o   final beat of a word (only with STREAM_DOWNSIZER_LAST_EN)
//
// State table:
//   ST_IDLE | no word held, ready for a new input word
//   ST_SEND | word held in word_q, beat_q selects the beat being presented
module stream_downsizer #(
    parameter int IN_WIDTH  = 32,
    parameter int RATIO     = 4,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [IN_WIDTH-1:0]       in_data_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    output logic [IN_WIDTH/RATIO-1:0] out_data_o,
    output logic                      out_valid_o,
`ifdef STREAM_DOWNSIZER_LAST_EN
    output logic                      out_last_o,
`endif
    input  logic                      out_ready_i
);

    localparam int OW = IN_WIDTH / RATIO;
    localparam int BW = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [BW-1:0] LAST_BEAT = BW'(RATIO - 1);

    if (RATIO < 1) begin : g_bad_ratio
        $error("stream_downsizer: RATIO must be at least 1");
    end
    if ((IN_WIDTH % RATIO) != 0) begin : g_bad_width
        $error("stream_downsizer: IN_WIDTH must be a multiple of RATIO");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic [BW-1:0]             beat_q, beat_d;
    logic [RATIO-1:0][OW-1:0]  word_q;
    logic [BW-1:0]             slice_sel;
    logic                      busy;
    logic                      last_beat;
    logic                      in_fire;
    logic                      out_fire;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            if (in_fire) begin
                word_q <= in_data_i;
            end
        end
    end

    always_comb begin
        busy       = (state_q == ST_SEND);
        last_beat  = busy && (beat_q == LAST_BEAT);
        // Ready while idle, or on the last beat when it is being taken, so a
        // new word can be loaded with no bubble.
        in_ready_o = !rst_i && (!busy || (last_beat && out_ready_i));
        in_fire    = in_valid_i && in_ready_o;
        out_fire   = busy && out_ready_i;

        state_d = state_q;
        beat_d  = beat_q;
        if (in_fire) begin
            state_d = ST_SEND;
            beat_d  = '0;
        end else if (out_fire) begin
            if (last_beat) begin
                state_d = ST_IDLE;
                beat_d  = '0;
            end else begin
                beat_d = beat_q + BW'(1);
            end
        end
    end

    always_comb begin
        slice_sel   = MSB_FIRST ? (LAST_BEAT - beat_q) : beat_q;
        out_data_o  = word_q[slice_sel];
        out_valid_o = busy;
    end

`ifdef STREAM_DOWNSIZER_LAST_EN
    assign out_last_o = last_beat;
`endif

endmodule

// File: tb/tb_stream_downsizer.sv
// Testbench for stream_downsizer: a per-cycle vector table on a 32/4 LSB-first
// instance, plus hand-written sequences for MSB-first back-to-back words and a
// RATIO=1 pipeline under random backpressure.
module tb_stream_downsizer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // instance A: 32/4, LSB first
    logic        rst_a, vin_a, ordy_a, rdy_a, vld_a;
    logic [31:0] din_a;
    logic [7:0]  dout_a;
    // instance M: 32/4, MSB first
    logic        rst_m, vin_m, ordy_m, rdy_m, vld_m;
    logic [31:0] din_m;
    logic [7:0]  dout_m;
    // instance R: 8/1
    logic        rst_r, vin_r, ordy_r, rdy_r, vld_r;
    logic [7:0]  din_r, dout_r;
`ifdef STREAM_DOWNSIZER_LAST_EN
    logic        last_a, last_m, last_r;
`endif

    stream_downsizer #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(1'b0)) u_lsb (
        .clk_i(clk), .rst_i(rst_a), .in_data_i(din_a), .in_valid_i(vin_a),
        .in_ready_o(rdy_a), .out_data_o(dout_a), .out_valid_o(vld_a),
`ifdef STREAM_DOWNSIZER_LAST_EN
        .out_last_o(last_a),
`endif
        .out_ready_i(ordy_a));

    stream_downsizer #(.IN_WIDTH(32), .RATIO(4), .MSB_FIRST(1'b1)) u_msb (
        .clk_i(clk), .rst_i(rst_m), .in_data_i(din_m), .in_valid_i(vin_m),
        .in_ready_o(rdy_m), .out_data_o(dout_m), .out_valid_o(vld_m),
`ifdef STREAM_DOWNSIZER_LAST_EN
        .out_last_o(last_m),
`endif
        .out_ready_i(ordy_m));

    stream_downsizer #(.IN_WIDTH(8), .RATIO(1), .MSB_FIRST(1'b0)) u_r1 (
        .clk_i(clk), .rst_i(rst_r), .in_data_i(din_r), .in_valid_i(vin_r),
        .in_ready_o(rdy_r), .out_data_o(dout_r), .out_valid_o(vld_r),
`ifdef STREAM_DOWNSIZER_LAST_EN
        .out_last_o(last_r),
`endif
        .out_ready_i(ordy_r));

    typedef struct {
        logic        rst;
        logic [31:0] din;
        logic        vin;
        logic        ordy;
        logic        e_rdy;
        logic        e_vld;
        logic [7:0]  e_data;
        logic        chk_data;
        logic        e_last;
    } vec_t;

    function automatic vec_t mk(logic rst, logic [31:0] din, logic vin, logic ordy,
                                logic e_rdy, logic e_vld, logic [7:0] e_data,
                                logic chk_data, logic e_last);
        vec_t v;
        v.rst = rst; v.din = din; v.vin = vin; v.ordy = ordy;
        v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = e_data;
        v.chk_data = chk_data; v.e_last = e_last;
        return v;
    endfunction

    vec_t tv[32];

    initial begin
        // reset held with valid high
        for (int i = 0; i < 3; i++) tv[i] = mk(1, 32'hDDCCBBAA, 1, 1, 0, 0, 8'h00, 1, 0);
        // basic serialization
        tv[3]  = mk(0, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0, 0);
        tv[4]  = mk(0, 32'h0, 0, 1, 0, 1, 8'hAA, 1, 0);
        tv[5]  = mk(0, 32'h0, 0, 1, 0, 1, 8'hBB, 1, 0);
        tv[6]  = mk(0, 32'h0, 0, 1, 0, 1, 8'hCC, 1, 0);
        tv[7]  = mk(0, 32'h0, 0, 1, 1, 1, 8'hDD, 1, 1);
        // backpressure on beat BB, with a competing input word offered
        tv[8]  = mk(0, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0, 0);
        tv[9]  = mk(0, 32'h0, 0, 1, 0, 1, 8'hAA, 1, 0);
        for (int i = 10; i < 15; i++) tv[i] = mk(0, 32'h12345678, 1, 0, 0, 1, 8'hBB, 1, 0);
        tv[15] = mk(0, 32'h0, 0, 1, 0, 1, 8'hBB, 1, 0);
        tv[16] = mk(0, 32'h0, 0, 1, 0, 1, 8'hCC, 1, 0);
        tv[17] = mk(0, 32'h0, 0, 1, 1, 1, 8'hDD, 1, 1);
        // reset mid-word
        tv[18] = mk(0, 32'hDDCCBBAA, 1, 1, 1, 0, 8'h00, 0, 0);
        tv[19] = mk(0, 32'h0, 0, 1, 0, 1, 8'hAA, 1, 0);
        tv[20] = mk(1, 32'h0, 0, 1, 0, 1, 8'hBB, 1, 0);
        tv[21] = mk(0, 32'h0F0E0D0C, 1, 1, 1, 0, 8'h00, 0, 0);
        tv[22] = mk(0, 32'h0, 0, 1, 0, 1, 8'h0C, 1, 0);
        tv[23] = mk(0, 32'h0, 0, 1, 0, 1, 8'h0D, 1, 0);
        tv[24] = mk(0, 32'h0, 0, 1, 0, 1, 8'h0E, 1, 0);
        // stall on the last beat, then reload with no bubble
        tv[25] = mk(0, 32'h0, 0, 0, 0, 1, 8'h0F, 1, 1);
        tv[26] = mk(0, 32'h87654321, 1, 1, 1, 1, 8'h0F, 1, 1);
        tv[27] = mk(0, 32'h0, 0, 1, 0, 1, 8'h21, 1, 0);
        tv[28] = mk(0, 32'h0, 0, 1, 0, 1, 8'h43, 1, 0);
        tv[29] = mk(0, 32'h0, 0, 1, 0, 1, 8'h65, 1, 0);
        tv[30] = mk(0, 32'h0, 0, 1, 1, 1, 8'h87, 1, 1);
        tv[31] = mk(0, 32'h0, 0, 1, 1, 0, 8'h00, 0, 0);
    end

    initial begin
        logic [7:0] msb_exp [8];
        int nacc;
        int exp_out;
        int next_in;
        int cyc;
        logic prev_in_fire;

        rst_a = 1; vin_a = 0; din_a = '0; ordy_a = 1;
        rst_m = 1; vin_m = 0; din_m = '0; ordy_m = 1;
        rst_r = 1; vin_r = 0; din_r = '0; ordy_r = 0;
        @(posedge clk); #1;

        // ---- table-driven vectors on the LSB-first instance ----
        for (int i = 0; i < 32; i++) begin
            rst_a = tv[i].rst; din_a = tv[i].din; vin_a = tv[i].vin; ordy_a = tv[i].ordy;
            @(negedge clk);
            check($sformatf("v%0d in_ready", i), 64'(rdy_a), 64'(tv[i].e_rdy));
            check($sformatf("v%0d out_valid", i), 64'(vld_a), 64'(tv[i].e_vld));
            if (tv[i].chk_data)
                check($sformatf("v%0d out_data", i), 64'(dout_a), 64'(tv[i].e_data));
`ifdef STREAM_DOWNSIZER_LAST_EN
            check($sformatf("v%0d out_last", i), 64'(last_a), 64'(tv[i].e_last));
`endif
            @(posedge clk); #1;
        end

        // ---- MSB first, two words back to back ----
        msb_exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
        rst_m = 0; nacc = 0;
        for (int k = 0; k < 9; k++) begin
            vin_m = (nacc < 2);
            din_m = (nacc == 0) ? 32'h11223344 : 32'h55667788;
            @(negedge clk);
            if (k == 0) begin
                check("msb idle valid", 64'(vld_m), 64'(0));
            end else begin
                check($sformatf("msb beat%0d valid", k), 64'(vld_m), 64'(1));
                check($sformatf("msb beat%0d data", k), 64'(dout_m), 64'(msb_exp[k-1]));
`ifdef STREAM_DOWNSIZER_LAST_EN
                check($sformatf("msb beat%0d last", k), 64'(last_m), 64'(k == 4 || k == 8));
`endif
            end
            check($sformatf("msb c%0d in_ready", k), 64'(rdy_m), 64'(k == 0 || k == 4 || k == 8));
            if (vin_m && rdy_m) nacc++;
            @(posedge clk); #1;
        end
        vin_m = 0;
        @(negedge clk);
        check("msb after valid", 64'(vld_m), 64'(0));

        // ---- RATIO=1 pipeline under random backpressure ----
        @(posedge clk); #1;
        rst_r = 0;
        exp_out = 1; next_in = 1; cyc = 0; prev_in_fire = 0;
        while (exp_out <= 16 && cyc < 400) begin
            vin_r = (next_in <= 16);
            din_r = 8'(next_in);
            ordy_r = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_in_fire) check("r1 latency", 64'(vld_r), 64'(1));
            if (vld_r && ordy_r) begin
                check($sformatf("r1 beat%0d", exp_out), 64'(dout_r), 64'(exp_out));
`ifdef STREAM_DOWNSIZER_LAST_EN
                check("r1 last", 64'(last_r), 64'(1));
`endif
                exp_out++;
            end
            check("r1 in_ready", 64'(rdy_r), 64'(!vld_r || ordy_r));
            prev_in_fire = vin_r && rdy_r;
            if (prev_in_fire) next_in++;
            cyc++;
            @(posedge clk); #1;
        end
        check("r1 all beats received", 64'(exp_out), 64'(17));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
